nibble_serial_add_ctrl: RTL and testbench
=========================================

NIBBLE_SERIAL_ADD_CTRL -- requirements
Module: nibble_serial_add_ctrl

Interface
REQ-001 Parameter NIBBLES, default 4: operand width in 4-bit nibbles; W = 4*NIBBLES; legal range 2..8.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request; sampled on rising edge of clk.
REQ-005 sub  input  1  operation select: 0 = a+b, 1 = a-b; sampled with start.
REQ-006 a  input  W  operand A; sampled with start.
REQ-007 b  input  W  operand B; sampled with start.
REQ-008 busy  output  1  high while a computation is in progress.
REQ-009 done  output  1  one-cycle pulse marking a valid result.
REQ-010 result  output  W  sum or difference.
REQ-011 cout  output  1  final carry out (for sub: 1 = no borrow).

Function
REQ-012 The block SHALL compute with a single 4-bit add/sub nibble stage, one nibble per cycle, LSB nibble first, using an internal carry register.
REQ-013 States SHALL be IDLE, RUN and DONE; the nibble index counter is ceil(log2(NIBBLES)) bits wide.
REQ-014 In IDLE or DONE with start=1: latch a, b and sub; clear the nibble index to 0; load the carry register with sub; clear result; go to RUN.
REQ-015 In IDLE or DONE with start=0: go to or stay in IDLE.
REQ-016 In RUN, each edge SHALL write nibble[idx] of result = a_n + (b_n XOR {4{sub}}) + carry, update carry with the nibble carry-out, and increment idx.
REQ-017 On the RUN edge that processes idx = NIBBLES-1, the block SHALL load cout with the final carry and go to DONE.
REQ-018 Latency: with start accepted at edge E0, done SHALL be high exactly in the cycle after edge E(NIBBLES); busy SHALL be high for exactly NIBBLES cycles.
REQ-019 busy SHALL be high only in RUN; done SHALL be high only in DONE.
REQ-020 start during RUN SHALL be ignored, with no effect on latched operands, state or outputs.
REQ-021 Changes on a, b or sub after acceptance SHALL NOT affect the computation in progress.
REQ-022 start in DONE SHALL be accepted (back-to-back operation); done then falls on the next edge.
REQ-023 result and cout SHALL hold their final values through DONE and IDLE until the next acceptance.
REQ-024 Arithmetic SHALL be modulo 2^W; the carry out of the top nibble goes only to cout.

Reset
REQ-025 While rst_n=0, the block SHALL force state=IDLE, idx=0, carry=0, result=0, cout=0, busy=0, done=0, immediately and independently of clk.
REQ-026 Reset asserted during RUN SHALL abort the operation, and no done pulse SHALL follow.
REQ-027 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-028 Macro NIBBLE_SERIAL_OVF_EN: when defined, the block SHALL add output port ovf (1 bit) = signed overflow of the top nibble (carry into bit W-1 XOR carry out of bit W-1).
REQ-029 ovf SHALL be loaded together with cout, SHALL reset to 0, and SHALL hold like cout.
REQ-030 When NIBBLE_SERIAL_OVF_EN is undefined, the ovf port and its logic SHALL NOT exist; all other behaviour SHALL be unchanged.

Verification (NIBBLES=4)
REQ-031 Add: a=0x1234, b=0x0FCD, sub=0 -> after 4 busy cycles, done pulse with result=0x2201, cout=0.
REQ-032 Wrap: a=0xFFFF, b=0x0001, sub=0 -> result=0x0000, cout=1; with the macro defined, ovf=0.
REQ-033 Subtract with borrow: a=0x0005, b=0x0007, sub=1 -> result=0xFFFE, cout=0; then a=0x0007, b=0x0005 -> result=0x0002, cout=1.
REQ-034 Overflow (macro defined): a=0x7FFF, b=0x0001, sub=0 -> result=0x8000, ovf=1, cout=0.
REQ-035 Start during busy: second start with different operands during RUN -> ignored; first result delivered; start in the DONE cycle -> accepted, next done exactly 5 cycles later.
REQ-036 Reset mid-operation: rst_n=0 after 2 RUN cycles -> busy, done, result and cout go to 0 at once; no done pulse follows; a new start after release completes normally.

Source files
------------

// File: rtl/nibble_serial_add_ctrl.sv
// rtl/nibble_serial_add_ctrl.sv - nibble-serial W-bit adder/subtractor with IDLE/RUN/DONE control
// Optional signed-overflow output enabled by macro NIBBLE_SERIAL_OVF_EN.
module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   sub,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   cout
`ifdef NIBBLE_SERIAL_OVF_EN
  ,
  output logic                   ovf
`endif
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic          carry;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic          sub_q;

  logic [IW+1:0] sh;
  logic [3:0]    a_n;
  logic [3:0]    b_n;
  logic [4:0]    nib_sum;

  assign sh      = {idx, 2'b00};
  assign a_n     = a_q[sh +: 4];
  // Subtraction is a + ~b + 1; the +1 comes from carry being preloaded with sub.
  assign b_n     = b_q[sh +: 4] ^ {4{sub_q}};
  assign nib_sum = {1'b0, a_n} + {1'b0, b_n} + {4'b0000, carry};

  assign busy = (state == RUN);
  assign done = (state == DONE);

`ifdef NIBBLE_SERIAL_OVF_EN
  logic [3:0] low_sum;
  assign low_sum = {1'b0, a_n[2:0]} + {1'b0, b_n[2:0]} + {3'b000, carry};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      carry  <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      sub_q  <= 1'b0;
`ifdef NIBBLE_SERIAL_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_q    <= a;
            b_q    <= b;
            sub_q  <= sub;
            idx    <= '0;
            carry  <= sub;
            result <= '0;
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end
        RUN: begin
          result[sh +: 4] <= nib_sum[3:0];
          carry           <= nib_sum[4];
          idx             <= idx + IW'(1);
          if (idx == LAST) begin
            cout  <= nib_sum[4];
`ifdef NIBBLE_SERIAL_OVF_EN
            ovf   <= low_sum[3] ^ nib_sum[4];
`endif
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb/tb_nibble_serial_add_ctrl.sv - randomized self-checking bench for nibble_serial_add_ctrl
// Reference model uses whole-word arithmetic; ovf checks compile only with NIBBLE_SERIAL_OVF_EN.
module tb_nibble_serial_add_ctrl;

  localparam int NIBBLES = 4;
  localparam int W = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
`ifdef NIBBLE_SERIAL_OVF_EN
  logic         ovf;
`endif

  int n_checks = 0;
  int n_fail = 0;

  logic [W-1:0] exp_r;
  logic         exp_c;
  logic         exp_v;

  nibble_serial_add_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout)
`ifdef NIBBLE_SERIAL_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, expv, $time);
    end
  endtask

  task automatic model(input logic [W-1:0] ta, input logic [W-1:0] tb_b, input logic ts);
    longint ua, ub, full;
    ua = longint'(ta);
    ub = longint'(tb_b);
    if (!ts) begin
      full  = ua + ub;
      exp_c = (full >= (longint'(1) << W));
      exp_r = W'(full);
      exp_v = (ta[W-1] == tb_b[W-1]) && (exp_r[W-1] != ta[W-1]);
    end else begin
      full  = ua - ub;
      exp_c = (ua >= ub);
      exp_r = W'(full);
      exp_v = (ta[W-1] != tb_b[W-1]) && (exp_r[W-1] != ta[W-1]);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_result"}, 64'(result), 64'(exp_r));
    check({tag, "_cout"}, 64'(cout), 64'(exp_c));
`ifdef NIBBLE_SERIAL_OVF_EN
    check({tag, "_ovf"}, 64'(ovf), 64'(exp_v));
`endif
  endtask

  // Called at a negedge just before the accept edge; returns at the negedge of the done cycle.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_b, input logic ts,
                        input bit ign);
    start = 1'b1;
    a = ta;
    b = tb_b;
    sub = ts;
    model(ta, tb_b, ts);
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    sub = 1'($urandom);
    for (int i = 0; i < NIBBLES; i++) begin
      @(negedge clk);
      if (ign) begin
        start = (i < NIBBLES - 1);
        a = W'($urandom);
        b = W'($urandom);
        sub = 1'($urandom);
      end
      check("busy_run", 64'(busy), 64'(1));
      check("done_run", 64'(done), 64'(0));
    end
    @(negedge clk);
    check("done_pulse", 64'(done), 64'(1));
    check("busy_done", 64'(busy), 64'(0));
    check_outputs("op");
  endtask

  task automatic idle_hold();
    start = 1'b0;
    @(negedge clk);
    check("done_fall", 64'(done), 64'(0));
    check("busy_idle", 64'(busy), 64'(0));
    check_outputs("hold");
  endtask

  initial begin
    bit chain;
    logic [W-1:0] ra, rb;
    logic rs;

    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_result", 64'(result), 64'(0));
    check("rst_cout", 64'(cout), 64'(0));
`ifdef NIBBLE_SERIAL_OVF_EN
    check("rst_ovf", 64'(ovf), 64'(0));
`endif

    rst_n = 1'b1;
    run_op(16'h1234, 16'h0FCD, 1'b0, 1'b0);
    check("add_const", 64'(result), 64'h2201);
    idle_hold();

    @(negedge clk);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    check("wrap_cout", 64'(cout), 64'(1));
    idle_hold();

    @(negedge clk);
    run_op(16'h0005, 16'h0007, 1'b1, 1'b0);
    check("borrow_const", 64'(result), 64'hFFFE);
    run_op(16'h0007, 16'h0005, 1'b1, 1'b0);
    check("noborrow_const", 64'(result), 64'h0002);
    idle_hold();

    @(negedge clk);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    check("ovf_result", 64'(result), 64'h8000);
    idle_hold();

    @(negedge clk);
    run_op(16'h1111, 16'h2222, 1'b0, 1'b1);
    run_op(16'hABCD, 16'h1234, 1'b1, 1'b0);
    idle_hold();

    @(negedge clk);
    start = 1'b1;
    a = 16'h4321;
    b = 16'h1111;
    sub = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    check("abort_result", 64'(result), 64'(0));
    check("abort_cout", 64'(cout), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NIBBLES + 2; i++) begin
      @(negedge clk);
      check("abort_no_done", 64'(done), 64'(0));
      check("abort_no_busy", 64'(busy), 64'(0));
    end
    run_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
    idle_hold();

    chain = 1'b0;
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom);
      if (!chain) @(negedge clk);
      run_op(ra, rb, rs, ($urandom_range(0, 2) == 0));
      chain = 1'($urandom);
      if (!chain) idle_hold();
    end
    if (chain) idle_hold();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
